// File: rtl/csr_wport_arbiter.sv
// Arbitrates the CSR register-file write port between the WB-stage write and N_REQ hardware
// requesters (pipeline first, round-robin otherwise, starvation stall). Option: CSR_ARB_STATS_EN.
module csr_wport_arbiter #(
    parameter int N_REQ      = 3,
    parameter int STARVE_LIM = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_reg_write_en_WB,
    input  logic [11:0]           csr_addr_WB,
    input  logic [31:0]           csr_data_WB,
    input  logic [N_REQ-1:0]      req,
    input  logic [12*N_REQ-1:0]   req_addr,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      drop,
    output logic                  csr_stall_req,
    output logic                  csr_we,
    output logic [11:0]           csr_waddr,
`ifdef CSR_ARB_STATS_EN
    output logic [31:0]           csr_wdata,
    output logic [31:0]           stall_cycles,
    output logic [15:0]           drop_count
`else
    output logic [31:0]           csr_wdata
`endif
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_STARVE} state_t;

    state_t             r_state, w_state_next;
    logic [PTR_W-1:0]   r_ptr;
    logic [7:0]         r_wait, w_wait_next;
    logic [N_REQ-1:0]   r_ack, r_drop;
    logic               r_stall, r_we;
    logic [11:0]        r_waddr;
    logic [31:0]        r_wdata;

    logic [N_REQ-1:0]   w_pending, w_drop_vec, w_live, w_grant_vec;
    logic               w_grant_vld;
    logic [PTR_W-1:0]   w_grant_idx, w_ptr_next;

    // A request acked/dropped last cycle is still visible on req until the requester reacts.
    assign w_pending = req & ~(r_ack | r_drop);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_conflict
            assign w_drop_vec[gi] = csr_reg_write_en_WB && w_pending[gi] &&
                                    (req_addr[12*gi +: 12] == csr_addr_WB);
        end
    endgenerate

    assign w_live = w_pending & ~w_drop_vec;

    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        if (!csr_reg_write_en_WB) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!w_grant_vld && w_pending[idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = PTR_W'(idx);
                end
            end
        end
    end

    assign w_grant_vec = w_grant_vld ? (N_REQ'(1) << w_grant_idx) : '0;
    assign w_ptr_next  = (w_grant_idx == PTR_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        w_wait_next = r_wait;
        if (w_grant_vld || (w_live == '0))
            w_wait_next = '0;
        else if (r_wait != 8'(STARVE_LIM))
            w_wait_next = r_wait + 8'd1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_live != '0) w_state_next = ST_ARB;
            end
            ST_ARB: begin
                if (w_live == '0)
                    w_state_next = ST_IDLE;
                else if (w_wait_next == 8'(STARVE_LIM))
                    w_state_next = ST_STARVE;
            end
            ST_STARVE: begin
                if (w_grant_vld)
                    w_state_next = ((w_live & ~w_grant_vec) != '0) ? ST_ARB : ST_IDLE;
                else if (w_live == '0)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_wait  <= '0;
            r_ack   <= '0;
            r_drop  <= '0;
            r_stall <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            r_ack   <= w_grant_vec;
            r_drop  <= w_drop_vec;
            r_stall <= (w_state_next == ST_STARVE);
            if (w_grant_vld) r_ptr <= w_ptr_next;
            if (csr_reg_write_en_WB) begin
                r_we    <= 1'b1;
                r_waddr <= csr_addr_WB;
                r_wdata <= csr_data_WB;
            end else if (w_grant_vld) begin
                r_we    <= 1'b1;
                r_waddr <= req_addr[int'(w_grant_idx)*12 +: 12];
                r_wdata <= req_data[int'(w_grant_idx)*32 +: 32];
            end else begin
                r_we    <= 1'b0;
            end
        end
    end

    assign ack           = r_ack;
    assign drop          = r_drop;
    assign csr_stall_req = r_stall;
    assign csr_we        = r_we;
    assign csr_waddr     = r_waddr;
    assign csr_wdata     = r_wdata;

`ifdef CSR_ARB_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_drop_count;
    logic [3:0]  w_drop_cnt;
    logic [16:0] w_dc_sum;

    always_comb begin
        w_drop_cnt = '0;
        for (int k = 0; k < N_REQ; k++)
            w_drop_cnt = w_drop_cnt + 4'(w_drop_vec[k]);
    end

    assign w_dc_sum = {1'b0, r_drop_count} + 17'(w_drop_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_drop_count   <= '0;
        end else begin
            if (r_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
            r_drop_count <= w_dc_sum[16] ? 16'hFFFF : w_dc_sum[15:0];
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign drop_count   = r_drop_count;
`endif
endmodule

// File: tb/tb_csr_wport_arbiter.sv
// Directed bench for csr_wport_arbiter: pipeline priority, round-robin, starvation stall,
// address-conflict drop and reset; stats counters checked when CSR_ARB_STATS_EN is defined.
module tb_csr_wport_arbiter;
    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_en;
    logic [11:0]   wb_addr;
    logic [31:0]   wb_data;
    logic [N-1:0]  req;
    logic [12*N-1:0] req_addr;
    logic [32*N-1:0] req_data;
    logic [N-1:0]  ack, drop;
    logic          stall, we;
    logic [11:0]   waddr;
    logic [31:0]   wdata;
`ifdef CSR_ARB_STATS_EN
    logic [31:0]   stall_cycles;
    logic [15:0]   drop_count;
`endif

    int n_checks = 0;
    int n_err    = 0;

    csr_wport_arbiter #(.N_REQ(N), .STARVE_LIM(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .csr_reg_write_en_WB (wb_en),
        .csr_addr_WB         (wb_addr),
        .csr_data_WB         (wb_data),
        .req                 (req),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .ack                 (ack),
        .drop                (drop),
        .csr_stall_req       (stall),
        .csr_we              (we),
        .csr_waddr           (waddr),
`ifdef CSR_ARB_STATS_EN
        .csr_wdata           (wdata),
        .stall_cycles        (stall_cycles),
        .drop_count          (drop_count)
`else
        .csr_wdata           (wdata)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0; req = '0;
        req_addr = {12'h102, 12'h101, 12'h100};
        req_data = {32'hA2, 32'hA1, 32'hA0};
        step(); step();
        rst = 1'b0;
        check("rst_we", we, 0);
        check("rst_ack", ack, 0);
        check("rst_drop", drop, 0);
        check("rst_stall", stall, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);

        // Pipeline-only write, one cycle latency
        wb_en = 1'b1; wb_addr = 12'h300; wb_data = 32'h1888;
        step();
        wb_en = 1'b0;
        check("wb_we", we, 1);
        check("wb_waddr", waddr, 12'h300);
        check("wb_wdata", wdata, 32'h1888);
        check("wb_ack", ack, 0);
        step();
        check("idle_we", we, 0);

        // Three requesters, each drops req after its ack
        req = 3'b111;
        step(); check("rr_ack0", ack, 3'b001); check("rr_addr0", waddr, 12'h100); check("rr_data0", wdata, 32'hA0);
        req = 3'b110;
        step(); check("rr_ack1", ack, 3'b010); check("rr_addr1", waddr, 12'h101); check("rr_data1", wdata, 32'hA1);
        req = 3'b100;
        step(); check("rr_ack2", ack, 3'b100); check("rr_addr2", waddr, 12'h102); check("rr_data2", wdata, 32'hA2);
        req = 3'b000;
        step(); check("rr_done_ack", ack, 0); check("rr_done_we", we, 0);

        // Pointer back at 0: 011 -> req0 first, then req1; pointer ends at 2
        req = 3'b011;
        step(); check("ptr0_ack", ack, 3'b001);
        req = 3'b010;
        step(); check("ptr1_ack", ack, 3'b010);
        req = 3'b000;
        step();
        // Pointer at 2 with 011 pending wraps to req0; pointer ends at 1
        req = 3'b011;
        step(); check("wrap_ack", ack, 3'b001);
        req = 3'b010;
        step(); check("wrap_ack1", ack, 3'b010);
        req = 3'b000;
        step();
        // Pointer is now 2

        // Starvation: WB writes every cycle while req[1] waits
        req = 3'b010; wb_en = 1'b1; wb_addr = 12'h340; wb_data = 32'h77;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("starve_st%0d", i), stall, (i == 8) ? 1 : 0);
            check($sformatf("starve_ack%0d", i), ack, 0);
        end
        step();
        check("late_wb_we", we, 1);
        check("late_wb_addr", waddr, 12'h340);
        check("late_wb_stall", stall, 1);
        check("late_wb_ack", ack, 0);
        wb_en = 1'b0;
        step();
        check("starve_ack", ack, 3'b010);
        check("starve_addr", waddr, 12'h101);
        check("starve_fall", stall, 0);
`ifdef CSR_ARB_STATS_EN
        check("stall_cycles", stall_cycles, 2);
`endif
        req = 3'b000;
        step();
        check("post_ack", ack, 0);
        check("post_stall", stall, 0);

        // Address conflict: req0 at 0xB00 vs pipeline write to 0xB00
        req_addr[11:0] = 12'hB00;
        req = 3'b001; wb_en = 1'b1; wb_addr = 12'hB00; wb_data = 32'h55;
        step();
        check("cf_drop", drop, 3'b001);
        check("cf_ack", ack, 0);
        check("cf_waddr", waddr, 12'hB00);
        check("cf_wdata", wdata, 32'h55);
`ifdef CSR_ARB_STATS_EN
        check("drop_count", drop_count, 1);
`endif
        req = 3'b000; wb_en = 1'b0;
        step();
        check("cf_drop_end", drop, 0);
        check("cf_ack_end", ack, 0);

        // Reset while starving
        req = 3'b100; wb_en = 1'b1; wb_addr = 12'h340;
        for (int i = 0; i < 8; i++) step();
        check("rs_stall_pre", stall, 1);
        rst = 1'b1;
        step();
        check("rs_we", we, 0);
        check("rs_ack", ack, 0);
        check("rs_drop", drop, 0);
        check("rs_stall", stall, 0);
        check("rs_waddr", waddr, 0);
        check("rs_wdata", wdata, 0);
`ifdef CSR_ARB_STATS_EN
        check("rs_stall_cyc", stall_cycles, 0);
        check("rs_drop_cnt", drop_count, 0);
`endif
        rst = 1'b0; wb_en = 1'b0;
        step();
        check("rs_reack", ack, 3'b100);
        check("rs_restall", stall, 0);
        req = 3'b000;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
